// File: rtl/ker_perf_monitor.sv
// ker_perf_monitor
//   Multi-channel kernel activity/latency monitor. Each channel runs a
//   free-running elapsed-cycle timer. A capture stores the kernel's reported
//   count and the elapsed time. The channel also tracks the maximum latency and
//   counts completion events. Timers and event counters saturate and raise a
//   sticky overflow flag instead of wrapping. Results are read one channel at a
//   time through a registered request/select port.
//
//   Ports
//     clk_out_PROG      kernel clock, rising edge
//     axi_reset_n       synchronous active-low reset
//     ker_count         per-channel count, ch i at [i*CNT_W +: CNT_W]
//     ker_count_ap_vld  per-channel 1-cycle valid strobe
//     clear_all         1-cycle pulse, clears all channel state
//     rd_req / rd_sel   read request and the channel it selects
//     rd_valid          1-cycle pulse; rd_* hold the requested channel
//     rd_err            with rd_valid: rd_sel out of range, data zero
//     rd_count, rd_elapsed, rd_max_elapsed, rd_events, rd_ovf  channel fields
//     any_ovf           registered OR of all channel overflow flags

// Per-channel state. The next-state values are exported so that a read issued
// on the same edge as a capture returns the freshly captured data.
module ker_perf_ch #(
    parameter int CNT_W = 32,
    parameter int EVT_W = 16
) (
    input  logic             clk_out_PROG,
    input  logic             axi_reset_n,
    input  logic             clear_all,
    input  logic             ap_vld,
    input  logic [CNT_W-1:0] ker_count,
    output logic [CNT_W-1:0] nxt_count,
    output logic [CNT_W-1:0] nxt_elapsed,
    output logic [CNT_W-1:0] nxt_max,
    output logic [EVT_W-1:0] nxt_events,
    output logic             nxt_ovf,
    output logic             ovf
);
    logic [CNT_W-1:0] timer, nxt_timer;
    logic [CNT_W-1:0] count_cap, elapsed_cap, max_el;
    logic [EVT_W-1:0] events;
    logic             ovf_q;

    always_comb begin
        nxt_timer   = timer;
        nxt_count   = count_cap;
        nxt_elapsed = elapsed_cap;
        nxt_max     = max_el;
        nxt_events  = events;
        nxt_ovf     = ovf_q;
        if (clear_all) begin
            nxt_timer   = '0;
            nxt_count   = '0;
            nxt_elapsed = '0;
            nxt_max     = '0;
            nxt_events  = '0;
            nxt_ovf     = 1'b0;
        end else if (ap_vld && ker_count == '0) begin
            // A zero count marks a kernel start. It restarts timing but keeps
            // the history (max, events).
            nxt_timer   = '0;
            nxt_count   = '0;
            nxt_elapsed = '0;
            nxt_ovf     = 1'b0;
        end else if (ap_vld) begin
            // The timer holds on the capture edge. It is not reset, so later
            // captures report cumulative cycles since the last start marker.
            nxt_count   = ker_count;
            nxt_elapsed = timer;
            if (timer > max_el)
                nxt_max = timer;
            if (events == {EVT_W{1'b1}})
                nxt_ovf = 1'b1;
            else
                nxt_events = events + EVT_W'(1);
        end else begin
            if (timer == {CNT_W{1'b1}})
                nxt_ovf = 1'b1;
            else
                nxt_timer = timer + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_out_PROG) begin
        if (!axi_reset_n) begin
            timer       <= '0;
            count_cap   <= '0;
            elapsed_cap <= '0;
            max_el      <= '0;
            events      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            timer       <= nxt_timer;
            count_cap   <= nxt_count;
            elapsed_cap <= nxt_elapsed;
            max_el      <= nxt_max;
            events      <= nxt_events;
            ovf_q       <= nxt_ovf;
        end
    end

    assign ovf = ovf_q;
endmodule

module ker_perf_monitor #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int EVT_W = 16,
    parameter int SEL_W = 4
) (
    input  logic                  clk_out_PROG,
    input  logic                  axi_reset_n,
    input  logic [N_CH*CNT_W-1:0] ker_count,
    input  logic [N_CH-1:0]       ker_count_ap_vld,
    input  logic                  clear_all,
    input  logic                  rd_req,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CNT_W-1:0]      rd_elapsed,
    output logic [CNT_W-1:0]      rd_max_elapsed,
    output logic [EVT_W-1:0]      rd_events,
    output logic                  rd_ovf,
    output logic                  any_ovf
);
    logic [N_CH-1:0][CNT_W-1:0] nxt_count, nxt_elapsed, nxt_max;
    logic [N_CH-1:0][EVT_W-1:0] nxt_events;
    logic [N_CH-1:0]            nxt_ovf, ovf_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ker_perf_ch #(.CNT_W(CNT_W), .EVT_W(EVT_W)) u_ch (
            .clk_out_PROG (clk_out_PROG),
            .axi_reset_n  (axi_reset_n),
            .clear_all    (clear_all),
            .ap_vld       (ker_count_ap_vld[i]),
            .ker_count    (ker_count[i*CNT_W +: CNT_W]),
            .nxt_count    (nxt_count[i]),
            .nxt_elapsed  (nxt_elapsed[i]),
            .nxt_max      (nxt_max[i]),
            .nxt_events   (nxt_events[i]),
            .nxt_ovf      (nxt_ovf[i]),
            .ovf          (ovf_v[i])
        );
    end

    // Read mux. An out-of-range select matches no channel, so the data stays
    // zero and the missing hit becomes the error flag.
    logic             sel_hit;
    logic [CNT_W-1:0] sel_count, sel_elapsed, sel_max;
    logic [EVT_W-1:0] sel_events;
    logic             sel_ovf;

    always_comb begin
        sel_hit     = 1'b0;
        sel_count   = '0;
        sel_elapsed = '0;
        sel_max     = '0;
        sel_events  = '0;
        sel_ovf     = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_hit     = 1'b1;
                sel_count   = nxt_count[i];
                sel_elapsed = nxt_elapsed[i];
                sel_max     = nxt_max[i];
                sel_events  = nxt_events[i];
                sel_ovf     = nxt_ovf[i];
            end
        end
    end

    always_ff @(posedge clk_out_PROG) begin
        if (!axi_reset_n) begin
            rd_valid       <= 1'b0;
            rd_err         <= 1'b0;
            rd_count       <= '0;
            rd_elapsed     <= '0;
            rd_max_elapsed <= '0;
            rd_events      <= '0;
            rd_ovf         <= 1'b0;
            any_ovf        <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            any_ovf  <= |ovf_v;
            if (rd_req) begin
                rd_err         <= !sel_hit;
                rd_count       <= sel_count;
                rd_elapsed     <= sel_elapsed;
                rd_max_elapsed <= sel_max;
                rd_events      <= sel_events;
                rd_ovf         <= sel_ovf;
            end
        end
    end
endmodule

// File: tb/tb_ker_perf_monitor.sv
module tb_ker_perf_monitor;
    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int EVT_W = 4;
    localparam int SEL_W = 4;

    logic                  clk_out_PROG = 1'b0;
    logic                  axi_reset_n;
    logic [N_CH*CNT_W-1:0] ker_count;
    logic [N_CH-1:0]       ker_count_ap_vld;
    logic                  clear_all;
    logic                  rd_req;
    logic [SEL_W-1:0]      rd_sel;
    logic                  rd_valid, rd_err, rd_ovf, any_ovf;
    logic [CNT_W-1:0]      rd_count, rd_elapsed, rd_max_elapsed;
    logic [EVT_W-1:0]      rd_events;

    int total  = 0;
    int passed = 0;

    ker_perf_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .EVT_W(EVT_W), .SEL_W(SEL_W)) dut (
        .clk_out_PROG     (clk_out_PROG),
        .axi_reset_n      (axi_reset_n),
        .ker_count        (ker_count),
        .ker_count_ap_vld (ker_count_ap_vld),
        .clear_all        (clear_all),
        .rd_req           (rd_req),
        .rd_sel           (rd_sel),
        .rd_valid         (rd_valid),
        .rd_err           (rd_err),
        .rd_count         (rd_count),
        .rd_elapsed       (rd_elapsed),
        .rd_max_elapsed   (rd_max_elapsed),
        .rd_events        (rd_events),
        .rd_ovf           (rd_ovf),
        .any_ovf          (any_ovf)
    );

    always #5 clk_out_PROG = ~clk_out_PROG;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic             err;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] el;
        logic [CNT_W-1:0] mx;
        logic [EVT_W-1:0] ev;
        logic             ovf;
    } rd_vec_t;

    rd_vec_t tbl [6];

    task automatic tick();
        @(posedge clk_out_PROG);
        #1;
    endtask

    task automatic idle();
        ker_count_ap_vld = '0;
        clear_all        = 1'b0;
        rd_req           = 1'b0;
    endtask

    task automatic set_vld(input int ch, input logic [CNT_W-1:0] v);
        ker_count_ap_vld[ch]         = 1'b1;
        ker_count[ch*CNT_W +: CNT_W] = v;
    endtask

    task automatic req(input logic [SEL_W-1:0] s);
        rd_req = 1'b1;
        rd_sel = s;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    task automatic chk_rd(input string nm, input logic err, input logic [CNT_W-1:0] cnt,
                          input logic [CNT_W-1:0] el, input logic [CNT_W-1:0] mx,
                          input logic [EVT_W-1:0] ev, input logic ovf);
        chk({nm, ".valid"},   32'(rd_valid),       32'd1);
        chk({nm, ".err"},     32'(rd_err),         32'(err));
        chk({nm, ".count"},   32'(rd_count),       32'(cnt));
        chk({nm, ".elapsed"}, 32'(rd_elapsed),     32'(el));
        chk({nm, ".max"},     32'(rd_max_elapsed), 32'(mx));
        chk({nm, ".events"},  32'(rd_events),      32'(ev));
        chk({nm, ".ovf"},     32'(rd_ovf),         32'(ovf));
    endtask

    initial begin
        //         sel    err   cnt  el    mx    ev  ovf
        tbl[0] = '{4'd4,  1'b1, 8'd0, 8'd0,   8'd0,   4'd0, 1'b0};
        tbl[1] = '{4'd2,  1'b0, 8'd0, 8'd0,   8'd0,   4'd0, 1'b0};
        tbl[2] = '{4'd3,  1'b0, 8'd0, 8'd0,   8'd0,   4'd0, 1'b0};
        tbl[3] = '{4'd15, 1'b1, 8'd0, 8'd0,   8'd0,   4'd0, 1'b0};
        tbl[4] = '{4'd1,  1'b0, 8'd9, 8'd30,  8'd50,  4'd2, 1'b0};
        tbl[5] = '{4'd0,  1'b0, 8'd7, 8'd100, 8'd100, 4'd1, 1'b0};

        axi_reset_n = 1'b0;
        ker_count   = '0;
        rd_sel      = '0;
        idle();
        tick();
        tick();
        chk("rst.valid",   32'(rd_valid),       32'd0);
        chk("rst.err",     32'(rd_err),         32'd0);
        chk("rst.count",   32'(rd_count),       32'd0);
        chk("rst.elapsed", 32'(rd_elapsed),     32'd0);
        chk("rst.max",     32'(rd_max_elapsed), 32'd0);
        chk("rst.events",  32'(rd_events),      32'd0);
        chk("rst.ovf",     32'(rd_ovf),         32'd0);
        chk("rst.any_ovf", 32'(any_ovf),        32'd0);
        axi_reset_n = 1'b1;

        // start marker on every channel so all timers begin together
        ker_count_ap_vld = '1;
        ker_count        = '0;
        tick();
        idle();

        // T1: 100 idle cycles after start, then a capture of count 7
        repeat (100) tick();
        set_vld(0, 8'd7);
        tick();
        idle();
        req(4'd0);
        tick();
        idle();
        chk_rd("t1_ch0", 1'b0, 8'd7, 8'd100, 8'd100, 4'd1, 1'b0);

        // T2: ch1 captures at 50, restarts, captures at 30 with a same-edge read
        set_vld(1, 8'd0);
        tick();
        idle();
        repeat (50) tick();
        set_vld(1, 8'd3);
        tick();
        idle();
        set_vld(1, 8'd0);
        tick();
        idle();
        repeat (30) tick();
        set_vld(1, 8'd9);
        req(4'd1);
        tick();
        idle();
        chk_rd("t2_ch1", 1'b0, 8'd9, 8'd30, 8'd50, 4'd2, 1'b0);

        // T5: back-to-back reads, one per cycle, including out-of-range selects
        for (int k = 0; k < 6; k++) begin
            req(tbl[k].sel);
            tick();
            chk_rd($sformatf("tbl%0d", k), tbl[k].err, tbl[k].cnt, tbl[k].el,
                   tbl[k].mx, tbl[k].ev, tbl[k].ovf);
        end
        idle();
        tick();
        chk("tbl.valid_drop", 32'(rd_valid), 32'd0);
        chk("tbl.hold_count", 32'(rd_count), 32'd7);
        chk("tbl.any_ovf",    32'(any_ovf),  32'd0);

        // T4: clear_all wins over a same-cycle capture on ch2
        set_vld(2, 8'd6);
        tick();
        idle();
        clear_all = 1'b1;
        set_vld(2, 8'd5);
        req(4'd2);
        tick();
        idle();
        chk_rd("t4_ch2", 1'b0, 8'd0, 8'd0, 8'd0, 4'd0, 1'b0);
        req(4'd0);
        tick();
        idle();
        chk_rd("t4_ch0", 1'b0, 8'd0, 8'd0, 8'd0, 4'd0, 1'b0);

        // T3: timers were zeroed by the clear and have advanced 1 since.
        // Edge 255 reaches all-ones; edge 256 sets ovf; any_ovf follows on 257.
        repeat (253) tick();
        req(4'd3);
        tick();
        idle();
        chk("t3.ovf_at_255", 32'(rd_ovf), 32'd0);
        req(4'd3);
        tick();
        idle();
        chk("t3.ovf_at_256", 32'(rd_ovf),  32'd1);
        chk("t3.any_lag",    32'(any_ovf), 32'd0);
        tick();
        chk("t3.any_set",    32'(any_ovf), 32'd1);
        repeat (40) tick();
        set_vld(3, 8'd1);
        req(4'd3);
        tick();
        idle();
        chk_rd("t3_cap", 1'b0, 8'd1, 8'd255, 8'd255, 4'd1, 1'b1);
        set_vld(3, 8'd0);
        req(4'd3);
        tick();
        idle();
        chk_rd("t3_start", 1'b0, 8'd0, 8'd0, 8'd255, 4'd1, 1'b0);

        // start markers on all channels clear every ovf; any_ovf lags by one
        ker_count_ap_vld = '1;
        ker_count        = '0;
        tick();
        idle();
        chk("any.lag_clear", 32'(any_ovf), 32'd1);
        tick();
        chk("any.cleared",   32'(any_ovf), 32'd0);

        // event counter saturation: 16 captures into a 4-bit counter
        for (int k = 0; k < 16; k++) begin
            set_vld(1, 8'd2);
            tick();
        end
        idle();
        req(4'd1);
        tick();
        idle();
        chk_rd("evt_sat", 1'b0, 8'd2, 8'd1, 8'd1, 4'd15, 1'b1);
        chk("evt_sat.any", 32'(any_ovf), 32'd1);

        // T6: reset mid-operation with a pending read request
        req(4'd0);
        axi_reset_n = 1'b0;
        tick();
        chk("t6.valid",   32'(rd_valid),       32'd0);
        chk("t6.count",   32'(rd_count),       32'd0);
        chk("t6.max",     32'(rd_max_elapsed), 32'd0);
        chk("t6.events",  32'(rd_events),      32'd0);
        chk("t6.ovf",     32'(rd_ovf),         32'd0);
        chk("t6.any_ovf", 32'(any_ovf),        32'd0);
        axi_reset_n = 1'b1;
        idle();
        tick();
        chk("t6.no_pulse", 32'(rd_valid), 32'd0);
        req(4'd1);
        tick();
        idle();
        chk_rd("t6_ch1", 1'b0, 8'd0, 8'd0, 8'd0, 4'd0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
